// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with valid/ready skid buffer
//
// Purpose: decodes the immediate field of a raw 32-bit instruction according
//    to a 3-bit format select, sign- or zero-extends it to XLEN bits and
//    presents it one registered stage later.  An output register plus one skid
//    register allow the downstream to stall without losing or duplicating work.
//
// Ports:
//    clk_i      in   1      clock, rising edge
//    rst_ni     in   1      synchronous active-low reset
//    valid_i    in   1      upstream instruction present
//    ready_o    out  1      block can accept this cycle (registered)
//    instr_i    in   32     raw instruction word
//    imm_src_i  in   3      format select: I,S,B,U,J,Z,SH,illegal
//    tag_i      in   TAG_W  opaque sideband, passed through
//    valid_o    out  1      imm_o/illegal_o/tag_o valid
//    ready_i    in   1      downstream accepts this cycle
//    imm_o      out  XLEN   extended immediate
//    illegal_o  out  1      format select was 3'b111
//    tag_o      out  TAG_W  sideband of the current output

module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [31:0]      instr_i,
   input  logic [2:0]       imm_src_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic             illegal_o,
   output logic [TAG_W-1:0] tag_o
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   // ---------------------------------------------------------------
   // Combinational format decode
   // ---------------------------------------------------------------
   logic            w_s;
   logic [31:0]     w_imm32;
   logic            w_sext;
   logic            w_ext;
   logic            w_illegal;
   logic [XLEN-1:0] w_imm;
   logic            w_unused_opcode;

   // The opcode bits never contribute to an immediate.
   assign w_unused_opcode = &{1'b0, instr_i[6:0]};

   assign w_s = instr_i[31];

   always_comb begin
      w_imm32   = '0;
      w_sext    = 1'b0;
      w_illegal = 1'b0;
      case (imm_src_i)
         3'b000: begin
            w_imm32 = {{20{w_s}}, instr_i[31:20]};
            w_sext  = 1'b1;
         end
         3'b001: begin
            w_imm32 = {{20{w_s}}, instr_i[31:25], instr_i[11:7]};
            w_sext  = 1'b1;
         end
         3'b010: begin
            w_imm32 = {{20{w_s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            w_sext  = 1'b1;
         end
         3'b011: begin
            w_imm32 = {instr_i[31:12], 12'b0};
            w_sext  = 1'b1;
         end
         3'b100: begin
            w_imm32 = {{12{w_s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            w_sext  = 1'b1;
         end
         3'b101: begin
            w_imm32 = {27'b0, instr_i[19:15]};
         end
         3'b110: begin
            // RV64 shift amounts carry one extra bit (instr[25]).
            if (XLEN == 64) w_imm32 = {26'b0, instr_i[25:20]};
            else            w_imm32 = {27'b0, instr_i[24:20]};
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   // Upper half (XLEN=64 only) replicates bit 31 for signed formats.
   assign w_ext = w_sext & w_imm32[31];

   always_comb begin
      w_imm       = '0;
      w_imm[31:0] = w_imm32;
      for (int k = 32; k < XLEN; k++) begin
         w_imm[k] = w_ext;
      end
   end

   // ---------------------------------------------------------------
   // Output register + skid register
   // ---------------------------------------------------------------
   logic             r_out_v;
   logic [XLEN-1:0]  r_out_imm;
   logic             r_out_ill;
   logic [TAG_W-1:0] r_out_tag;

   logic             r_skd_v;
   logic [XLEN-1:0]  r_skd_imm;
   logic             r_skd_ill;
   logic [TAG_W-1:0] r_skd_tag;

   logic             w_accept;
   logic             w_advance;

   // ready_o looks only at registered state, so no ready_i -> ready_o path.
   assign ready_o   = !r_skd_v;
   assign w_accept  = valid_i && !r_skd_v;
   assign w_advance = !r_out_v || ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_out_v   <= 1'b0;
         r_out_imm <= '0;
         r_out_ill <= 1'b0;
         r_out_tag <= '0;
         r_skd_v   <= 1'b0;
         r_skd_imm <= '0;
         r_skd_ill <= 1'b0;
         r_skd_tag <= '0;
      end else if (w_advance) begin
         if (r_skd_v) begin
            // SKD full implies ready_o=0, so nothing new can arrive here.
            r_out_v   <= 1'b1;
            r_out_imm <= r_skd_imm;
            r_out_ill <= r_skd_ill;
            r_out_tag <= r_skd_tag;
            r_skd_v   <= 1'b0;
         end else begin
            r_out_v <= w_accept;
            if (w_accept) begin
               r_out_imm <= w_imm;
               r_out_ill <= w_illegal;
               r_out_tag <= tag_i;
            end
         end
      end else if (w_accept) begin
         r_skd_v   <= 1'b1;
         r_skd_imm <= w_imm;
         r_skd_ill <= w_illegal;
         r_skd_tag <= tag_i;
      end
   end

   assign valid_o   = r_out_v;
   assign imm_o     = r_out_imm;
   assign illegal_o = r_out_ill;
   assign tag_o     = r_out_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN 32 and 64)

module tb_imm_gen_pipe;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic [31:0] instr_i;
   logic [2:0]  imm_src_i;
   logic [4:0]  tag_i;
   logic        ready_i;

   logic        ready_o_a, valid_o_a, illegal_o_a;
   logic [31:0] imm_o_a;
   logic [4:0]  tag_o_a;
   logic        ready_o_b, valid_o_b, illegal_o_b;
   logic [63:0] imm_o_b;
   logic [4:0]  tag_o_b;

   always #5 clk_i = ~clk_i;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o_a),
      .instr_i(instr_i), .imm_src_i(imm_src_i), .tag_i(tag_i),
      .valid_o(valid_o_a), .ready_i(ready_i), .imm_o(imm_o_a),
      .illegal_o(illegal_o_a), .tag_o(tag_o_a));

   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o_b),
      .instr_i(instr_i), .imm_src_i(imm_src_i), .tag_i(tag_i),
      .valid_o(valid_o_b), .ready_i(ready_i), .imm_o(imm_o_b),
      .illegal_o(illegal_o_b), .tag_o(tag_o_b));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] imm32;
      logic [63:0] imm64;
      logic        ill;
      logic [4:0]  tag;
   } ent_t;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [31:0] exp32;
      logic [63:0] exp64;
      logic        ill;
   } vec_t;

   ent_t         model_q[$];
   logic [4:0]   got_tags[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Sign-extend an n-bit field value as a plain integer.
   function automatic longint sx(input longint f, input int n);
      longint half;
      half = longint'(1) << (n - 1);
      return (f >= half) ? f - (half << 1) : f;
   endfunction

   // Reference decode: the immediate as an integer, then truncated to XLEN.
   function automatic logic [63:0] ref_imm(input logic [31:0] in, input logic [2:0] src,
                                           input bit wide);
      longint v;
      case (src)
         3'd0: v = sx(longint'(in[31:20]), 12);
         3'd1: v = sx(longint'({in[31:25], in[11:7]}), 12);
         3'd2: v = sx(longint'({in[31], in[7], in[30:25], in[11:8]}), 12) * 2;
         3'd3: v = sx(longint'(in[31:12]), 20) * 4096;
         3'd4: v = sx(longint'({in[31], in[19:12], in[20], in[30:21]}), 20) * 2;
         3'd5: v = longint'(in[19:15]);
         3'd6: v = wide ? longint'(in[25:20]) : longint'(in[24:20]);
         default: v = 0;
      endcase
      if (wide) return 64'(v);
      return {32'b0, v[31:0]};
   endfunction

   // Compare both DUTs against the model after an edge.
   task automatic check_outputs(input string ph);
      chk({ph, ".valid32"}, {63'b0, valid_o_a}, {63'b0, model_q.size() > 0});
      chk({ph, ".valid64"}, {63'b0, valid_o_b}, {63'b0, model_q.size() > 0});
      chk({ph, ".ready32"}, {63'b0, ready_o_a}, {63'b0, model_q.size() < 2});
      chk({ph, ".ready64"}, {63'b0, ready_o_b}, {63'b0, model_q.size() < 2});
      if (model_q.size() > 0) begin
         chk({ph, ".imm32"}, {32'b0, imm_o_a}, model_q[0].imm32);
         chk({ph, ".imm64"}, imm_o_b, model_q[0].imm64);
         chk({ph, ".ill"}, {62'b0, illegal_o_a, illegal_o_b}, {62'b0, model_q[0].ill, model_q[0].ill});
         chk({ph, ".tag"}, {54'b0, tag_o_a, tag_o_b}, {54'b0, model_q[0].tag, model_q[0].tag});
      end
   endtask

   // One clock: drive inputs (just after the previous edge), update model, check.
   task automatic cyc(input string ph, input bit v, input logic [31:0] ins,
                      input logic [2:0] src, input logic [4:0] tg, input bit rdy,
                      output bit acc);
      ent_t e;
      valid_i   = v;
      instr_i   = ins;
      imm_src_i = src;
      tag_i     = tg;
      ready_i   = rdy;
      if (valid_o_a && rdy) got_tags.push_back(tag_o_a);
      acc = v && (model_q.size() < 2);
      if (model_q.size() > 0 && rdy) void'(model_q.pop_front());
      if (acc) begin
         e.imm32 = ref_imm(ins, src, 1'b0);
         e.imm64 = ref_imm(ins, src, 1'b1);
         e.ill   = (src == 3'b111);
         e.tag   = tg;
         model_q.push_back(e);
      end
      @(posedge clk_i);
      #1;
      check_outputs(ph);
   endtask

   task automatic do_reset();
      valid_i = 1'b0;
      ready_i = 1'b0;
      rst_ni  = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      model_q.delete();
      chk("rst.valid", {62'b0, valid_o_a, valid_o_b}, 64'd0);
      chk("rst.imm32", {32'b0, imm_o_a}, 64'd0);
      chk("rst.imm64", imm_o_b, 64'd0);
      chk("rst.ill", {62'b0, illegal_o_a, illegal_o_b}, 64'd0);
      chk("rst.tag", {54'b0, tag_o_a, tag_o_b}, 64'd0);
      chk("rst.ready", {62'b0, ready_o_a, ready_o_b}, 64'd3);
   endtask

   vec_t vecs[$];

   initial begin : main
      bit          acc;
      logic [63:0] held_imm;
      int          n;

      valid_i = 0; instr_i = 0; imm_src_i = 0; tag_i = 0; ready_i = 0; rst_ni = 0;

      vecs.push_back('{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0});
      vecs.push_back('{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0});
      vecs.push_back('{32'hFFFFF06F, 3'b100, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0});
      vecs.push_back('{32'h123450B7, 3'b011, 32'h12345000, 64'h0000000012345000, 1'b0});
      vecs.push_back('{32'h80000037, 3'b011, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0});
      vecs.push_back('{32'h02A01013, 3'b110, 32'h0000000A, 64'h000000000000002A, 1'b0});
      vecs.push_back('{32'h000FD073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0});
      vecs.push_back('{32'hDEADBEEF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1});
      vecs.push_back('{32'hFE0007A3, 3'b001, 32'hFFFFFFEF, 64'hFFFFFFFFFFFFFFEF, 1'b0});
      vecs.push_back('{32'h7FF00013, 3'b000, 32'h000007FF, 64'h00000000000007FF, 1'b0});
      vecs.push_back('{32'h00000463, 3'b010, 32'h00000008, 64'h0000000000000008, 1'b0});
      vecs.push_back('{32'hFFFFFFFF, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0});
      vecs.push_back('{32'hFFFFFFFF, 3'b110, 32'h0000001F, 64'h000000000000003F, 1'b0});

      do_reset();

      // Table vectors, back-to-back with ready_i=1: each shows up one edge later.
      foreach (vecs[i]) begin
         cyc("tbl", 1'b1, vecs[i].instr, vecs[i].src, 5'(i + 1), 1'b1, acc);
         chk($sformatf("tbl%0d.valid", i), {63'b0, valid_o_a}, 64'd1);
         chk($sformatf("tbl%0d.imm32", i), {32'b0, imm_o_a}, {32'b0, vecs[i].exp32});
         chk($sformatf("tbl%0d.imm64", i), imm_o_b, vecs[i].exp64);
         chk($sformatf("tbl%0d.ill", i), {63'b0, illegal_o_a}, {63'b0, vecs[i].ill});
         chk($sformatf("tbl%0d.tag", i), {59'b0, tag_o_b}, 64'(i + 1));
      end
      cyc("drain", 1'b0, 32'h0, 3'b0, 5'd0, 1'b1, acc);

      // Invalid inputs are ignored whatever the instruction bits.
      cyc("idle", 1'b0, 32'hFFFFFFFF, 3'b111, 5'd31, 1'b1, acc);
      chk("idle.valid", {62'b0, valid_o_a, valid_o_b}, 64'd0);

      // Backpressure: tags 1,2,3 on consecutive cycles, ready_i low 4 cycles.
      got_tags.delete();
      cyc("bp", 1'b1, 32'hFFF00093, 3'b000, 5'd1, 1'b0, acc);
      held_imm = imm_o_b;
      cyc("bp", 1'b1, 32'h123450B7, 3'b011, 5'd2, 1'b0, acc);
      chk("bp.ready_low", {62'b0, ready_o_a, ready_o_b}, 64'd0);
      cyc("bp", 1'b1, 32'h000FD073, 3'b101, 5'd3, 1'b0, acc);
      chk("bp.tag3_held", {63'b0, acc}, 64'd0);
      chk("bp.stable", imm_o_b, held_imm);
      cyc("bp", 1'b1, 32'h000FD073, 3'b101, 5'd3, 1'b0, acc);
      chk("bp.stable", imm_o_b, held_imm);
      chk("bp.stable_tag", {59'b0, tag_o_a}, 64'd1);
      n = 0;
      acc = 0;
      while (!acc && n < 8) begin
         cyc("bp.rel", 1'b1, 32'h000FD073, 3'b101, 5'd3, 1'b1, acc);
         n++;
      end
      chk("bp.tag3_accepted", {63'b0, acc}, 64'd1);
      for (int k = 0; k < 4; k++) cyc("bp.drain", 1'b0, 32'h0, 3'b0, 5'd0, 1'b1, acc);
      chk("bp.count", 64'(got_tags.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < got_tags.size())
            chk($sformatf("bp.order%0d", k), {59'b0, got_tags[k]}, 64'(k + 1));
      end

      // Reset with OUT and SKD both full: held tags must vanish.
      got_tags.delete();
      cyc("rm", 1'b1, 32'hFFFFF06F, 3'b100, 5'd9, 1'b0, acc);
      cyc("rm", 1'b1, 32'hFE000EE3, 3'b010, 5'd10, 1'b0, acc);
      chk("rm.full", {62'b0, ready_o_a, ready_o_b}, 64'd0);
      do_reset();
      for (int k = 0; k < 3; k++) cyc("rm.after", 1'b0, 32'h0, 3'b0, 5'd0, 1'b1, acc);
      chk("rm.no_ghost", 64'(got_tags.size()), 64'd0);

      // Random soak against the queue model.
      for (int k = 0; k < 3000; k++) begin
         cyc("soak", 1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
             5'($urandom), 1'($urandom_range(0, 2) != 0), acc);
      end
      for (int k = 0; k < 3; k++) cyc("soak.drain", 1'b0, 32'h0, 3'b0, 5'd0, 1'b1, acc);
      chk("soak.empty", 64'(model_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It takes a raw 32-bit instruction word plus an immediate-format select, and produces a sign- or zero-extended XLEN-bit immediate through one registered stage. A valid/ready skid buffer lets decode stall without dropping or duplicating instructions. It extends the base I/S/B/U/J formats with RV64 widening, CSR zimm, shift-amount formats and an illegal-format flag.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- TAG_W, 5, width of opaque sideband carried alongside each immediate (e.g. rd index / ROB tag)
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- valid_i  input  1  upstream has an instruction
- ready_o  output  1  block can accept this cycle
- instr_i  input  32  raw instruction word
- imm_src_i  input  3  format select (see Operation)
- tag_i  input  TAG_W  sideband, passed through unchanged
- valid_o  output  1  imm_o/illegal_o/tag_o valid
- ready_i  input  1  downstream accepts this cycle
- imm_o  output  XLEN  extended immediate
- illegal_o  output  1  imm_src_i was 3'b111
- tag_o  output  TAG_W  sideband of the current output

## Operation
- Format decode (combinational, before the register), with s = instr_i[31] replicated to XLEN:
  - 000 I: s, instr[31:20]
  - 001 S: s, instr[31:25], instr[11:7]
  - 010 B: s, instr[7], instr[30:25], instr[11:8], 0
  - 011 U: s above bit 31 (XLEN=64 only), instr[31:12], 12'b0
  - 100 J: s, instr[19:12], instr[20], instr[30:21], 0
  - 101 Z (CSR uimm): zero-extended instr[19:15]
  - 110 SH (shamt): zero-extended instr[24:20] when XLEN=32; zero-extended instr[25:20] when XLEN=64
  - 111: imm = 0, illegal = 1
- illegal = 0 for every other format.
- Storage: an output register (OUT) and one skid register (SKD). Each holds {imm, illegal, tag, valid}.
- ready_o = !SKD.valid. It is registered-state-derived only and never depends combinationally on ready_i.
- Input acceptance: an input is accepted when valid_i && ready_o.
- Per cycle, evaluated in priority order:
  - OUT empty or (valid_o && ready_i):
    - If SKD valid: OUT <- SKD; SKD <- accepted input if any, else SKD empties.
    - Else: OUT <- accepted input if any, else OUT empties.
  - OUT held (valid_o && !ready_i): an accepted input goes to SKD.
- Ordering is strict FIFO. There is no loss and no duplication. Maximum occupancy is 2.
- XLEN not in {32,64} is an elaboration error.

## Timing
- Reset (rst_ni low at a rising edge):
  - valid_o=0, imm_o=0, illegal_o=0, tag_o=0.
  - SKD cleared, so ready_o=1 on the cycle after reset.
  - Any in-flight entries are discarded.
- Latency: an input accepted at edge N appears on valid_o/imm_o after edge N. That is one cycle, when the path is unstalled.
- Throughput: 1 per cycle while ready_i=1.
- Stall: the first stalled input sits in OUT and the next goes to SKD. ready_o drops the cycle after SKD fills.
- Release: on the first ready_i=1, the SKD contents move to OUT and ready_o returns to 1 the next cycle.
- Output data (imm_o, illegal_o, tag_o) holds stable while valid_o && !ready_i.
- Inputs with valid_i=0 are ignored regardless of instr_i/imm_src_i.
- Simultaneous drain and accept with OUT full and SKD empty: OUT is replaced by the new input in the same edge (no bubble).

## Test plan
- I/B/J, XLEN=32, ready_i=1:
  - 0xFFF00093/000 -> imm_o 0xFFFFFFFF
  - 0xFE000EE3/010 -> 0xFFFFFFFC
  - 0xFFFFF06F/100 -> 0xFFFFFFFE
  - Each appears one cycle after acceptance, back-to-back, with illegal_o=0.
- U and widening:
  - 0x123450B7/011 -> 0x12345000
  - With XLEN=64, 0x80000037/011 -> 0xFFFFFFFF80000000
  - With XLEN=64, 0x02A01013/110 -> 0x2A (shamt 42)
- Z and illegal:
  - 0x000FD073/101 -> 0x1F
  - Any instr/111 -> imm_o 0, illegal_o 1, tag_o equal to the tag sent
- Backpressure: tags 1,2,3 sent on consecutive cycles, ready_i=0 for 4 cycles, then 1.
  - ready_o goes low after tag 2 is captured and tag 3 is held upstream.
  - Outputs are exactly 1,2,3 in order, and imm_o stays stable during the stall.
- Reset mid-operation: with OUT and SKD both full, assert rst_ni=0 for one edge.
  - Next cycle: valid_o=0, imm_o=0, ready_o=1.
  - Previously held tags never appear.
- Random soak: random valid_i/ready_i, checked against a golden FIFO-plus-decode model.
  - No drop or duplicate, and ready_o never low while SKD is empty.
